// File: rtl/alu_frame_ctrl_pkg.sv
// rtl/alu_frame_ctrl_pkg.sv - shared types and constants for the ALU frame controller
//
// Purpose: holds the controller state encoding, the response status codes and
//          the default frame start marker.
// Ports:   none (package).

package alu_frame_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_GET_OP    = 3'd1,
      ST_GET_A     = 3'd2,
      ST_GET_B     = 3'd3,
      ST_GET_CHK   = 3'd4,
      ST_EXEC      = 3'd5,
      ST_SEND_STAT = 3'd6,
      ST_SEND_RES  = 3'd7
   } state_e;

   localparam logic [7:0] STAT_OK      = 8'h00;
   localparam logic [7:0] STAT_CHK     = 8'h01;
   localparam logic [7:0] STAT_TMO     = 8'h02;
   localparam logic [7:0] SYNC_DEFAULT = 8'hA5;

   // States in which a frame is being received and the idle timer runs.
   function automatic logic is_rx_state(state_e s);
      return (s == ST_GET_OP) || (s == ST_GET_A) || (s == ST_GET_B) || (s == ST_GET_CHK);
   endfunction

endpackage

// File: rtl/alu_frame_ctrl_if.sv
// rtl/alu_frame_ctrl_if.sv - FIFO and ALU bus between the frame controller and its environment
//
// Purpose: bundles the RX FIFO, TX FIFO and ALU operand/result signals.
// Signals: i_data_to_read/i_fifo_rx_empty/o_fifo_rx_read   RX FIFO head and pop
//          i_fifo_tx_full/o_fifo_tx_write/o_data_to_write  TX FIFO push
//          o_alu_opcode/o_alu_op_A/o_alu_op_B/i_alu_result  external ALU
// Modports: slave  - the controller (drives the o_* signals)
//           master - the environment (drives the i_* signals)

interface alu_frame_ctrl_if #(
   parameter int NB_DATA    = 8,
   parameter int NB_OPCODE  = 6,
   parameter int N_BYTES_OP = 2
) ();
   localparam int NB_OPERAND = NB_DATA * N_BYTES_OP;

   logic [NB_DATA-1:0]    i_data_to_read;
   logic                  i_fifo_rx_empty;
   logic                  i_fifo_tx_full;
   logic [NB_OPERAND-1:0] i_alu_result;
   logic                  o_fifo_rx_read;
   logic                  o_fifo_tx_write;
   logic [NB_DATA-1:0]    o_data_to_write;
   logic [NB_OPCODE-1:0]  o_alu_opcode;
   logic [NB_OPERAND-1:0] o_alu_op_A;
   logic [NB_OPERAND-1:0] o_alu_op_B;

   modport slave (
      input  i_data_to_read, i_fifo_rx_empty, i_fifo_tx_full, i_alu_result,
      output o_fifo_rx_read, o_fifo_tx_write, o_data_to_write,
             o_alu_opcode, o_alu_op_A, o_alu_op_B
   );

   modport master (
      output i_data_to_read, i_fifo_rx_empty, i_fifo_tx_full, i_alu_result,
      input  o_fifo_rx_read, o_fifo_tx_write, o_data_to_write,
             o_alu_opcode, o_alu_op_A, o_alu_op_B
   );
endinterface

// File: rtl/alu_frame_ctrl_frame_timeout.sv
// rtl/alu_frame_ctrl_frame_timeout.sv - inter-byte idle timer for frame reception
//
// Purpose: counts idle clocks while enabled; reports expiry at TIMEOUT_CYCLES-1.
// Ports:   i_clk    clock, rising edge
//          i_reset  asynchronous active-low reset
//          clear    restart the count (a byte was consumed)
//          enable   timer runs; when low the count is held at zero
//          expired  count has reached TIMEOUT_CYCLES-1 with no clear

module frame_timeout #(
   parameter int TIMEOUT_CYCLES = 50000
) (
   input  logic i_clk,
   input  logic i_reset,
   input  logic clear,
   input  logic enable,
   output logic expired
);
   localparam int CNT_W = $clog2((TIMEOUT_CYCLES > 2) ? TIMEOUT_CYCLES : 2);
   localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clear || !enable) begin
         cnt_d = '0;
      end else if (cnt_q != LIMIT) begin
         // Saturate so a stalled consumer cannot wrap the count back to zero.
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expired = enable && !clear && (cnt_q == LIMIT);

endmodule

// File: rtl/alu_frame_ctrl.sv
// rtl/alu_frame_ctrl.sv - UART framed command parser and ALU response generator
//
// Purpose: pops bytes from the RX FIFO, parses SYNC/OPCODE/A/B/CHK frames,
//          drives registered operands to an external ALU, and pushes a
//          status byte followed (on success) by the result bytes to the TX FIFO.
// Ports:   i_clk        clock, rising edge
//          i_reset      asynchronous active-low reset
//          bus          FIFO/ALU bus (slave side)
//          o_busy       high whenever the controller is not in IDLE
//          o_frame_done one-cycle pulse with the last result byte push

module alu_frame_ctrl
   import alu_frame_ctrl_pkg::*;
#(
   parameter int                 NB_DATA        = 8,
   parameter int                 NB_OPCODE      = 6,
   parameter int                 N_BYTES_OP     = 2,
   parameter int                 TIMEOUT_CYCLES = 50000,
   parameter logic [NB_DATA-1:0] SYNC_BYTE      = SYNC_DEFAULT
) (
   input  logic             i_clk,
   input  logic             i_reset,
   alu_frame_ctrl_if.slave  bus,
   output logic             o_busy,
   output logic             o_frame_done
);
   localparam int NB_OPERAND = NB_DATA * N_BYTES_OP;
   localparam int CNT_W      = (N_BYTES_OP > 1) ? $clog2(N_BYTES_OP) : 1;
   localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(N_BYTES_OP - 1);

   state_e                state_q, state_d;
   logic [CNT_W-1:0]      byte_cnt_q, byte_cnt_d;
   logic [NB_DATA-1:0]    chk_q, chk_d;
   logic [NB_DATA-1:0]    data_wr_q, data_wr_d;
   logic [NB_OPCODE-1:0]  opcode_q, opcode_d;
   logic [NB_OPERAND-1:0] op_a_q, op_a_d;
   logic [NB_OPERAND-1:0] op_b_q, op_b_d;
   logic [NB_OPERAND-1:0] result_q, result_d;
   logic                  run_q, run_d;

   logic                  rx_pop;
   logic                  tx_push;
   logic                  frame_done;
   logic                  rx_avail;
   logic                  tx_ready;
   logic                  rx_phase;
   logic                  tmo_expired;
   logic [NB_DATA-1:0]    rx_byte;
   logic [CNT_W-1:0]      next_cnt;

   frame_timeout #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_timeout (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .clear   (rx_pop),
      .enable  (rx_phase),
      .expired (tmo_expired)
   );

   always_comb begin
      state_d    = state_q;
      byte_cnt_d = byte_cnt_q;
      chk_d      = chk_q;
      data_wr_d  = data_wr_q;
      opcode_d   = opcode_q;
      op_a_d     = op_a_q;
      op_b_d     = op_b_q;
      result_d   = result_q;
      run_d      = 1'b1;
      rx_pop     = 1'b0;
      tx_push    = 1'b0;
      frame_done = 1'b0;

      // run_q is low during reset and for one clock after it, so the
      // combinational strobes cannot fire while the block is held in reset.
      rx_byte  = bus.i_data_to_read;
      rx_avail = run_q && !bus.i_fifo_rx_empty;
      tx_ready = run_q && !bus.i_fifo_tx_full;
      rx_phase = is_rx_state(state_q);
      next_cnt = byte_cnt_q + CNT_W'(1);

      case (state_q)
         ST_IDLE: begin
            if (rx_avail) begin
               rx_pop = 1'b1;
               if (rx_byte == SYNC_BYTE) begin
                  chk_d      = '0;
                  byte_cnt_d = '0;
                  state_d    = ST_GET_OP;
               end
            end
         end

         ST_GET_OP: begin
            if (rx_avail) begin
               rx_pop   = 1'b1;
               opcode_d = NB_OPCODE'(rx_byte);
               chk_d    = chk_q ^ rx_byte;
               state_d  = ST_GET_A;
            end
         end

         ST_GET_A: begin
            if (rx_avail) begin
               rx_pop = 1'b1;
               op_a_d[int'(byte_cnt_q)*NB_DATA +: NB_DATA] = rx_byte;
               chk_d = chk_q ^ rx_byte;
               if (byte_cnt_q == LAST_BYTE) begin
                  byte_cnt_d = '0;
                  state_d    = ST_GET_B;
               end else begin
                  byte_cnt_d = next_cnt;
               end
            end
         end

         ST_GET_B: begin
            if (rx_avail) begin
               rx_pop = 1'b1;
               op_b_d[int'(byte_cnt_q)*NB_DATA +: NB_DATA] = rx_byte;
               chk_d = chk_q ^ rx_byte;
               if (byte_cnt_q == LAST_BYTE) begin
                  byte_cnt_d = '0;
                  state_d    = ST_GET_CHK;
               end else begin
                  byte_cnt_d = next_cnt;
               end
            end
         end

         ST_GET_CHK: begin
            if (rx_avail) begin
               rx_pop = 1'b1;
               if (rx_byte == chk_q) begin
                  state_d = ST_EXEC;
               end else begin
                  data_wr_d = NB_DATA'(STAT_CHK);
                  state_d   = ST_SEND_STAT;
               end
            end
         end

         ST_EXEC: begin
            // Operands have been stable since the last B byte, so the
            // ALU output is settled here.
            result_d  = bus.i_alu_result;
            data_wr_d = NB_DATA'(STAT_OK);
            state_d   = ST_SEND_STAT;
         end

         ST_SEND_STAT: begin
            if (tx_ready) begin
               tx_push = 1'b1;
               if (data_wr_q == NB_DATA'(STAT_OK)) begin
                  data_wr_d  = result_q[NB_DATA-1:0];
                  byte_cnt_d = '0;
                  state_d    = ST_SEND_RES;
               end else begin
                  state_d = ST_IDLE;
               end
            end
         end

         ST_SEND_RES: begin
            // data_wr_q already holds byte byte_cnt_q; preload the next one.
            if (tx_ready) begin
               tx_push = 1'b1;
               if (byte_cnt_q == LAST_BYTE) begin
                  frame_done = 1'b1;
                  byte_cnt_d = '0;
                  state_d    = ST_IDLE;
               end else begin
                  data_wr_d  = result_q[int'(next_cnt)*NB_DATA +: NB_DATA];
                  byte_cnt_d = next_cnt;
               end
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // A stalled partial frame is abandoned and reported.
      if (rx_phase && !rx_pop && tmo_expired) begin
         data_wr_d  = NB_DATA'(STAT_TMO);
         byte_cnt_d = '0;
         state_d    = ST_SEND_STAT;
      end
   end

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         state_q    <= ST_IDLE;
         byte_cnt_q <= '0;
         chk_q      <= '0;
         data_wr_q  <= '0;
         opcode_q   <= '0;
         op_a_q     <= '0;
         op_b_q     <= '0;
         result_q   <= '0;
         run_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         byte_cnt_q <= byte_cnt_d;
         chk_q      <= chk_d;
         data_wr_q  <= data_wr_d;
         opcode_q   <= opcode_d;
         op_a_q     <= op_a_d;
         op_b_q     <= op_b_d;
         result_q   <= result_d;
         run_q      <= run_d;
      end
   end

   assign bus.o_fifo_rx_read  = rx_pop;
   assign bus.o_fifo_tx_write = tx_push;
   assign bus.o_data_to_write = data_wr_q;
   assign bus.o_alu_opcode    = opcode_q;
   assign bus.o_alu_op_A      = op_a_q;
   assign bus.o_alu_op_B      = op_b_q;
   assign o_busy              = (state_q != ST_IDLE);
   assign o_frame_done        = frame_done;

endmodule

// File: tb/tb_alu_frame_ctrl.sv
// tb/tb_alu_frame_ctrl.sv - self-checking bench for alu_frame_ctrl

module tb_alu_frame_ctrl;
   localparam int TMO = 200;

   logic clk = 1'b0;
   logic rst_n;
   logic busy, done;
   always #5 clk = ~clk;

   alu_frame_ctrl_if #(.NB_DATA(8), .NB_OPCODE(6), .N_BYTES_OP(2)) bus ();

   alu_frame_ctrl #(
      .NB_DATA(8), .NB_OPCODE(6), .N_BYTES_OP(2),
      .TIMEOUT_CYCLES(TMO), .SYNC_BYTE(8'hA5)
   ) dut (
      .i_clk(clk), .i_reset(rst_n), .bus(bus),
      .o_busy(busy), .o_frame_done(done)
   );

   logic [7:0] rxq[$];
   logic [7:0] txq[$];
   logic [7:0] exp[$];
   logic       tx_full_en = 1'b0;
   logic       rx_hold = 1'b0;
   int         total = 0;
   int         bad = 0;
   int         done_cnt = 0;

   // External ALU behaviour.
   function automatic logic [15:0] alu_ref(logic [5:0] op, logic [15:0] a, logic [15:0] b);
      case (op)
         6'h20:   return a + b;
         6'h22:   return a - b;
         6'h24:   return a & b;
         default: return a ^ b;
      endcase
   endfunction

   // One clock: present FIFO/ALU inputs, act on the strobes the DUT will see at the edge.
   task automatic step();
      bus.i_fifo_rx_empty = rx_hold || (rxq.size() == 0);
      bus.i_data_to_read  = (rxq.size() != 0) ? rxq[0] : 8'h00;
      bus.i_fifo_tx_full  = tx_full_en;
      bus.i_alu_result    = alu_ref(bus.o_alu_opcode, bus.o_alu_op_A, bus.o_alu_op_B);
      #1;
      if (bus.o_fifo_rx_read) begin
         total++;
         if (bus.i_fifo_rx_empty !== 1'b0) begin
            bad++;
            $display("FAIL rx_pop_while_empty got=1 want=0");
         end else begin
            void'(rxq.pop_front());
         end
      end
      if (bus.o_fifo_tx_write) begin
         total++;
         if (tx_full_en) begin
            bad++;
            $display("FAIL tx_push_while_full got=1 want=0");
         end else begin
            txq.push_back(bus.o_data_to_write);
         end
      end
      if (done) done_cnt++;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic run_idle(input int budget, output bit ok);
      int n = 0;
      do begin
         step();
         n++;
      end while (!(rxq.size() == 0 && !busy) && n < budget);
      ok = (rxq.size() == 0 && !busy);
   endtask

   task automatic push_frame(input logic [7:0] op, input logic [15:0] a, input logic [15:0] b,
                             input bit corrupt);
      logic [7:0] c;
      c = op ^ a[7:0] ^ a[15:8] ^ b[7:0] ^ b[15:8];
      if (corrupt) c = c ^ 8'h5C;
      rxq.push_back(8'hA5); rxq.push_back(op);
      rxq.push_back(a[7:0]); rxq.push_back(a[15:8]);
      rxq.push_back(b[7:0]); rxq.push_back(b[15:8]);
      rxq.push_back(c);
   endtask

   task automatic test_reset();
      rst_n = 1'b1;
      #2;
      rst_n = 1'b0;
      rxq = {8'h55};
      step(); step();
      bus.i_fifo_rx_empty = 1'b0;
      #1;
      total++; if (bus.o_fifo_rx_read !== 1'b0) begin bad++; $display("FAIL reset_rx_read got=%0b want=0", bus.o_fifo_rx_read); end
      total++; if (bus.o_fifo_tx_write !== 1'b0) begin bad++; $display("FAIL reset_tx_write got=%0b want=0", bus.o_fifo_tx_write); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0b want=0", busy); end
      total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%0b want=0", done); end
      total++; if (bus.o_data_to_write !== 8'h00) begin bad++; $display("FAIL reset_data got=%0h want=0", bus.o_data_to_write); end
      total++; if ({bus.o_alu_opcode, bus.o_alu_op_A, bus.o_alu_op_B} !== 38'h0) begin bad++; $display("FAIL reset_alu_ops got=%0h want=0", {bus.o_alu_opcode, bus.o_alu_op_A, bus.o_alu_op_B}); end
      total++; if (rxq.size() != 1) begin bad++; $display("FAIL reset_no_pop got=%0d want=1", rxq.size()); end
      @(negedge clk);
      rst_n = 1'b1;
      begin
         bit ok;
         run_idle(50, ok);
         total++; if (!ok) begin bad++; $display("FAIL reset_release_idle got=0 want=1"); end
      end
      total++; if (txq.size() != 0) begin bad++; $display("FAIL reset_garbage_tx got=%0d want=0", txq.size()); end
   endtask

   task automatic test_basic();
      bit ok;
      txq.delete(); done_cnt = 0;
      rxq = {8'hA5, 8'h20, 8'h34, 8'h12, 8'h01, 8'h00, 8'h07};
      exp = {8'h00, 8'h35, 8'h12};
      run_idle(100, ok);
      total++; if (!ok) begin bad++; $display("FAIL basic_idle got=0 want=1"); end
      total++;
      if (txq.size() != exp.size()) begin bad++; $display("FAIL basic_tx_len got=%0d want=%0d", txq.size(), exp.size()); end
      else foreach (exp[i]) begin
         total++; if (txq[i] !== exp[i]) begin bad++; $display("FAIL basic_tx[%0d] got=%0h want=%0h", i, txq[i], exp[i]); end
      end
      total++; if (done_cnt != 1) begin bad++; $display("FAIL basic_done got=%0d want=1", done_cnt); end
      total++; if (bus.o_alu_op_A !== 16'h1234) begin bad++; $display("FAIL basic_op_a got=%0h want=1234", bus.o_alu_op_A); end
      total++; if (bus.o_alu_op_B !== 16'h0001) begin bad++; $display("FAIL basic_op_b got=%0h want=0001", bus.o_alu_op_B); end
      total++; if (bus.o_alu_opcode !== 6'h20) begin bad++; $display("FAIL basic_opcode got=%0h want=20", bus.o_alu_opcode); end
   endtask

   task automatic test_garbage();
      bit ok;
      txq.delete(); done_cnt = 0;
      rxq = {8'h00, 8'hFF, 8'hA5, 8'h20, 8'h34, 8'h12, 8'h01, 8'h00, 8'h07};
      exp = {8'h00, 8'h35, 8'h12};
      run_idle(100, ok);
      total++; if (!ok) begin bad++; $display("FAIL garbage_idle got=0 want=1"); end
      total++;
      if (txq.size() != exp.size()) begin bad++; $display("FAIL garbage_tx_len got=%0d want=%0d", txq.size(), exp.size()); end
      else foreach (exp[i]) begin
         total++; if (txq[i] !== exp[i]) begin bad++; $display("FAIL garbage_tx[%0d] got=%0h want=%0h", i, txq[i], exp[i]); end
      end
   endtask

   task automatic test_bad_chk();
      bit ok;
      txq.delete(); done_cnt = 0;
      rxq = {8'hA5, 8'h20, 8'h34, 8'h12, 8'h01, 8'h00, 8'h08};
      run_idle(100, ok);
      total++; if (!ok) begin bad++; $display("FAIL badchk_idle got=0 want=1"); end
      total++; if (txq.size() != 1) begin bad++; $display("FAIL badchk_tx_len got=%0d want=1", txq.size()); end
      else begin
         total++; if (txq[0] !== 8'h01) begin bad++; $display("FAIL badchk_status got=%0h want=01", txq[0]); end
      end
      total++; if (done_cnt != 0) begin bad++; $display("FAIL badchk_done got=%0d want=0", done_cnt); end
   endtask

   task automatic test_timeout();
      bit ok;
      txq.delete(); done_cnt = 0;
      rxq = {8'hA5, 8'h20};
      repeat (TMO / 2) step();
      total++; if (busy !== 1'b1 || txq.size() != 0) begin bad++; $display("FAIL tmo_early busy=%0b tx=%0d want busy=1 tx=0", busy, txq.size()); end
      repeat (TMO / 2 + 20) step();
      total++; if (txq.size() != 1) begin bad++; $display("FAIL tmo_tx_len got=%0d want=1", txq.size()); end
      else begin
         total++; if (txq[0] !== 8'h02) begin bad++; $display("FAIL tmo_status got=%0h want=02", txq[0]); end
      end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL tmo_idle got=%0b want=0", busy); end
      txq.delete();
      push_frame(8'h20, 16'h1234, 16'h0001, 1'b0);
      exp = {8'h00, 8'h35, 8'h12};
      run_idle(100, ok);
      total++;
      if (txq.size() != exp.size()) begin bad++; $display("FAIL tmo_next_len got=%0d want=%0d", txq.size(), exp.size()); end
      else foreach (exp[i]) begin
         total++; if (txq[i] !== exp[i]) begin bad++; $display("FAIL tmo_next[%0d] got=%0h want=%0h", i, txq[i], exp[i]); end
      end
      total++; if (done_cnt != 1) begin bad++; $display("FAIL tmo_next_done got=%0d want=1", done_cnt); end
   endtask

   task automatic test_tx_full();
      bit ok;
      int n = 0;
      logic [7:0] held;
      txq.delete(); done_cnt = 0;
      tx_full_en = 1'b1;
      rxq = {8'hA5, 8'h20, 8'h34, 8'h12, 8'h01, 8'h00, 8'h07};
      while (rxq.size() != 0 && n < 50) begin step(); n++; end
      total++; if (rxq.size() != 0) begin bad++; $display("FAIL full_consume got=%0d want=0", rxq.size()); end
      repeat (5) step();
      held = bus.o_data_to_write;
      repeat (35) step();
      total++; if (txq.size() != 0 || busy !== 1'b1) begin bad++; $display("FAIL full_stall tx=%0d busy=%0b want tx=0 busy=1", txq.size(), busy); end
      total++; if (bus.o_data_to_write !== 8'h00 || held !== 8'h00) begin bad++; $display("FAIL full_hold got=%0h/%0h want=00", held, bus.o_data_to_write); end
      tx_full_en = 1'b0;
      exp = {8'h00, 8'h35, 8'h12};
      run_idle(100, ok);
      total++;
      if (txq.size() != exp.size()) begin bad++; $display("FAIL full_tx_len got=%0d want=%0d", txq.size(), exp.size()); end
      else foreach (exp[i]) begin
         total++; if (txq[i] !== exp[i]) begin bad++; $display("FAIL full_tx[%0d] got=%0h want=%0h", i, txq[i], exp[i]); end
      end
   endtask

   task automatic test_reset_mid();
      bit ok;
      int n = 0;
      txq.delete(); done_cnt = 0;
      rxq = {8'hA5, 8'h20, 8'h34};
      while (rxq.size() != 0 && n < 20) begin step(); n++; end
      step();
      rst_n = 1'b0;
      rxq = {8'h12};
      repeat (3) step();
      total++; if (busy !== 1'b0 || rxq.size() != 1) begin bad++; $display("FAIL rstmid_abort busy=%0b rx=%0d want busy=0 rx=1", busy, rxq.size()); end
      rst_n = 1'b1;
      push_frame(8'h20, 16'h1234, 16'h0001, 1'b0);
      exp = {8'h00, 8'h35, 8'h12};
      run_idle(100, ok);
      total++;
      if (txq.size() != exp.size()) begin bad++; $display("FAIL rstmid_tx_len got=%0d want=%0d", txq.size(), exp.size()); end
      else foreach (exp[i]) begin
         total++; if (txq[i] !== exp[i]) begin bad++; $display("FAIL rstmid_tx[%0d] got=%0h want=%0h", i, txq[i], exp[i]); end
      end
   endtask

   task automatic test_random();
      int n = 0;
      int good = 0;
      txq.delete(); exp.delete(); done_cnt = 0;
      for (int f = 0; f < 20; f++) begin
         logic [7:0]  op, g;
         logic [15:0] a, b, r;
         bit          corrupt;
         for (int k = $urandom_range(0, 2); k > 0; k--) begin
            g = 8'($urandom);
            if (g == 8'hA5) g = 8'h5A;
            rxq.push_back(g);
         end
         case ($urandom_range(0, 3))
            0: op = 8'h20;
            1: op = 8'h22 | 8'($urandom_range(0, 3) << 6);
            2: op = 8'h24;
            default: op = 8'($urandom);
         endcase
         a = 16'($urandom);
         b = 16'($urandom);
         corrupt = ($urandom_range(0, 3) == 0);
         push_frame(op, a, b, corrupt);
         if (corrupt) begin
            exp.push_back(8'h01);
         end else begin
            r = alu_ref(op[5:0], a, b);
            exp.push_back(8'h00); exp.push_back(r[7:0]); exp.push_back(r[15:8]);
            good++;
         end
      end
      do begin
         tx_full_en = ($urandom_range(0, 3) == 0);
         rx_hold    = ($urandom_range(0, 4) == 0);
         step();
         n++;
      end while (!(rxq.size() == 0 && !busy) && n < 4000);
      tx_full_en = 1'b0;
      rx_hold    = 1'b0;
      total++; if (n >= 4000) begin bad++; $display("FAIL rand_budget got=%0d want<4000", n); end
      total++;
      if (txq.size() != exp.size()) begin bad++; $display("FAIL rand_tx_len got=%0d want=%0d", txq.size(), exp.size()); end
      else foreach (exp[i]) begin
         total++; if (txq[i] !== exp[i]) begin bad++; $display("FAIL rand_tx[%0d] got=%0h want=%0h", i, txq[i], exp[i]); end
      end
      total++; if (done_cnt != good) begin bad++; $display("FAIL rand_done got=%0d want=%0d", done_cnt, good); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_garbage();
      test_bad_chk();
      test_timeout();
      test_tx_full();
      test_reset_mid();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
